kpd_scanner: RTL

Parametrised matrix-keypad scanner with debounce and key-event handshake. It drives one-cold active-low column strobes and samples active-low row inputs through a 2-flop synchroniser. A press is accepted only after `DEBOUNCE` stable cycles and is presented as an encoded key code on a valid/ready interface. The block sits between the keypad pins and the key-consuming control logic.

---
 rtl/kpd_pkg.sv | 25 ++
 rtl/kpd_scanner_if.sv | 11 +
 rtl/kpd_coldrv.sv | 32 +++
 rtl/kpd_scanner.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/kpd_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package kpd_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } kpd_state_t;

  // Active-low one-cold strobe: column idx of n drives bit (n-1-idx) low.
  function automatic logic [31:0] onecold(input int unsigned idx, input int unsigned n);
    return ~(32'd1 << (n - 32'd1 - idx));
  endfunction

  // True when exactly one of the low n bits of pat is zero.
  function automatic logic row_onehot_ok(input logic [31:0] pat, input int unsigned n);
    int unsigned zeros;
    zeros = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n && ((pat >> i) & 32'd1) == 32'd0) zeros++;
    end
    return zeros == 1;
  endfunction

endpackage

// File: rtl/kpd_scanner_if.sv
// Key-event valid/ready handshake between the scanner and its consumer.
interface kpd_scanner_if #(
  parameter int unsigned CODE_W = 4
);
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/kpd_coldrv.sv
// Column index counter with registered one-cold active-low strobe decode.
module kpd_coldrv
  import kpd_pkg::*;
#(
  parameter int unsigned NCOLS = 4,
  parameter int unsigned CW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             hold,
  output logic [CW-1:0]    col,
  output logic [NCOLS-1:0] kpc
);

  // Step to the next column (wrapping) and re-decode the strobe in the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      kpc <= NCOLS'(onecold(0, NCOLS));
    end else if (advance && !hold) begin
      if (col == CW'(NCOLS - 1)) begin
        col <= '0;
        kpc <= NCOLS'(onecold(0, NCOLS));
      end else begin
        col <= col + 1'b1;
        kpc <= NCOLS'(onecold(32'(col) + 32'd1, NCOLS));
      end
    end
  end

endmodule

// File: rtl/kpd_scanner.sv
// Matrix keypad scanner: column strobing, row synchronisation, debounce,
// and a valid/ready key-event output with sticky overrun.
module kpd_scanner
  import kpd_pkg::*;
#(
  parameter int unsigned NCOLS    = 4,
  parameter int unsigned NROWS    = 4,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NROWS-1:0] kpr,
  output logic [NCOLS-1:0] kpc,
  kpd_scanner_if.master    key_if,
  output logic             key_down,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int unsigned CODE_W  = $clog2(NROWS * NCOLS);
  localparam int unsigned CW      = ($clog2(NCOLS) > 1) ? $clog2(NCOLS) : 1;
  localparam int unsigned RW      = ($clog2(NROWS) > 1) ? $clog2(NROWS) : 1;
  localparam int unsigned CNT_MAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  kpd_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [RW-1:0]     row;
  logic [RW-1:0]     row_sel;
  logic [NROWS-1:0]  pattern;
  logic [NROWS-1:0]  sync1;
  logic [NROWS-1:0]  kpr_s;
  logic [CW-1:0]     col;
  logic [CODE_W-1:0] code;
  logic              dwell_last;
  logic              single_row;
  logic              release_done;
  logic              advance;
  logic              hold;

  // Two-flop synchroniser for the asynchronous row inputs; idle level is all ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      kpr_s <= '1;
    end else begin
      sync1 <= kpr;
      kpr_s <= sync1;
    end
  end

  // Row index of the (single) low row; row 0 is the MSB of kpr_s.
  always_comb begin
    row_sel = '0;
    for (int unsigned r = 0; r < NROWS; r++) begin
      if (kpr_s[NROWS-1-r] == 1'b0) row_sel = RW'(r);
    end
  end

  // Column stepping: idle/ghost sample in SCAN, or a confirmed release in HELD.
  always_comb begin
    dwell_last   = (state == SCAN) && (cnt == CNT_W'(SETTLE - 1));
    single_row   = row_onehot_ok(32'(kpr_s), NROWS);
    release_done = (state == HELD) && (kpr_s == '1) && (cnt == CNT_W'(DEBOUNCE - 1));
    advance      = (dwell_last && !single_row) || release_done;
    hold         = (state != SCAN) && !release_done;
    code         = CODE_W'(row) * CODE_W'(NCOLS) + CODE_W'(col);
  end

  kpd_coldrv #(
    .NCOLS (NCOLS),
    .CW    (CW)
  ) u_coldrv (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (advance),
    .hold    (hold),
    .col     (col),
    .kpc     (kpc)
  );

  // Scan/confirm/held FSM with registered event, key_down and overrun outputs.
  // One counter serves as dwell, press-stable and release-stable count since
  // the three uses never overlap in time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= SCAN;
      cnt              <= '0;
      row              <= '0;
      pattern          <= '1;
      key_if.key_code  <= '0;
      key_if.key_valid <= 1'b0;
      key_down         <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      if (key_if.key_valid && key_if.key_ready) key_if.key_valid <= 1'b0;
      if (clr_overrun) overrun <= 1'b0;

      unique case (state)
        SCAN: begin
          if (dwell_last) begin
            cnt <= '0;
            if (single_row) begin
              row     <= row_sel;
              pattern <= kpr_s;
              state   <= CONFIRM;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONFIRM: begin
          if (kpr_s != pattern) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
            state    <= HELD;
            cnt      <= '0;
            key_down <= 1'b1;
            if (!key_if.key_valid || key_if.key_ready) begin
              key_if.key_code  <= code;
              key_if.key_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (kpr_s != '1) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
            state    <= SCAN;
            cnt      <= '0;
            key_down <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
